prince_cfb_ctrl: RTL and testbench
==================================

Name: prince_cfb_ctrl

Overview:
- Sequencer that runs the 16-bit-slice prince_core in CFB-64 mode behind a 16-bit streaming interface.
- For each 64-bit keystream block it issues four core operations on the 64-bit feedback register (outer_idx 3,2,1,0, MSB slice first) and collects the results into E.
- It XORs E with the next four input words and reloads the feedback register with the 64-bit ciphertext block.
- Keys k0/k1 go straight to the core. This block owns only start, slice and data sequencing.

Parameters:
- TIMEOUT_CYC, default 64: maximum number of cycles from core_start to core_done before a timeout error is raised.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- decrypt  in  1  mode select, 0 = encrypt, 1 = decrypt; sampled on iv_load
- iv_load  in  1  single-cycle pulse: load iv, start a new stream
- iv  in  64  initial vector
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid & s_ready
- s_data  in  16  plaintext (encrypt) or ciphertext (decrypt) word
- s_last  in  1  final word of the stream
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  16  output word
- m_last  out  1  mirrors s_last of the matching input word
- core_start  out  1  one-cycle start pulse to prince_core block_start
- core_encrypt  out  1  tied to 1 (CFB uses the forward cipher only)
- core_idx  out  2  drives prince_core outer_idx
- core_din  out  16  drives prince_core plain_text
- core_done  in  1  prince_core block_done, one-cycle pulse
- core_dout  in  16  prince_core cipher_text, valid when core_done=1
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  sticky; cleared by iv_load

Behaviour:
- Reset values: all outputs 0 except core_encrypt=1. State=IDLE, fb=0, E=0, slice counter=3, word counter=0.
- IDLE:
  - s_ready=0.
  - On iv_load: fb<=iv, latch decrypt, clear err_timeout, go to GEN.
- GEN:
  - For slice = 3 down to 0: assert core_start for one cycle with core_idx=slice and core_din=fb[16*slice+15 : 16*slice].
  - Wait for core_done, then E[16*slice+15 : 16*slice] <= core_dout.
  - The next core_start follows no earlier than the cycle after core_done.
  - After slice 0 completes, go to XOR with word counter w=0.
- XOR:
  - s_ready = ~m_valid | m_ready (single-entry output register).
  - On accept of word w: m_data <= s_data ^ E[63-16w : 48-16w], m_valid<=1, m_last<=s_last.
  - Feedback slot w <= m_data (encrypt) or s_data (decrypt).
  - If s_last: go to IDLE once the word is accepted. The partial block is not fed back.
  - Else if w==3: fb <= the new 64-bit feedback block, go to GEN.
  - Else: w<=w+1.
- m_valid clears on m_ready when no new word is accepted in the same cycle. The output register drains independently of state.
- Throughput: four core operations, then four words. Generation and consumption do not overlap.
- iv_load in any non-IDLE state aborts the stream:
  - If a core operation is outstanding, go to DRAIN, discard the result on core_done (or on timeout), then apply the pending IV and go to GEN.
  - Otherwise apply it immediately.
  - s_ready=0 in the iv_load cycle; iv_load wins over a simultaneous s_valid.
  - m_valid/m_data already present are not flushed.
- Timeout: a counter runs from core_start. If it reaches TIMEOUT_CYC without core_done, set err_timeout=1 and go to IDLE. A late core_done is ignored.
- core_done in any state other than an outstanding wait is ignored.
- Asynchronous reset mid-operation returns all state to reset values immediately.

Decomposition:
- Shared package prince_cfb_pkg holds:
  - the state enum {IDLE, GEN, XOR, DRAIN};
  - SEG_W=16, BLK_W=64, NUM_SLICES=4;
  - a slice-select function returning the 16-bit slice for a given index.
- No sub-module. The timeout counter and the output register are inline.

Test Plan:
- Reference environment: a stub core with core_dout = core_din ^ 16'hA5A5 and core_done 3 cycles after core_start.
- Encrypt, iv=64'h0123456789ABCDEF, four zero input words -> core_idx sequence 3,2,1,0 with core_din 0123,4567,89AB,CDEF; m_data = A486,E0C2,2C0E,684A. Next GEN core_din = A486,E0C2,2C0E,684A.
- Decrypt with the same iv, input A486,E0C2,2C0E,684A -> m_data = 0000 ×4; next fb = 64'hA486E0C22C0E684A.
- Back-pressure: hold m_ready=0 for 5 cycles after the first output -> s_ready=0 for those cycles, m_data held at A486, no word lost or duplicated.
- s_last on word 1 -> m_last=1 on the second output, busy=0 afterwards, no further core_start.
- iv_load=64'h1 one cycle after core_start of slice 2 -> DRAIN; the slice-2 result is discarded; GEN restarts with core_idx=3, core_din=0000.
- Stub never asserts core_done, TIMEOUT_CYC=64 -> err_timeout=1 exactly 64 cycles after core_start, state IDLE; the next iv_load clears err_timeout.

Source files
------------

// File: rtl/prince_cfb_pkg.sv
// Shared types and helpers for the PRINCE CFB-64 sequencer.
// Slice widths, state encoding and slice selection.
package prince_cfb_pkg;

  localparam int SEG_W      = 16;
  localparam int BLK_W      = 64;
  localparam int NUM_SLICES = 4;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    XOR,
    DRAIN
  } state_e;

  function automatic logic [SEG_W-1:0] slice_sel(
    input logic [BLK_W-1:0] blk,
    input logic [1:0]       idx
  );
    return blk[SEG_W*int'(idx) +: SEG_W];
  endfunction

endpackage

// File: rtl/prince_cfb_ctrl.sv
// CFB-64 sequencer around a 16-bit-slice PRINCE core.
// Generates a keystream block, then XORs it over four stream words.
module prince_cfb_ctrl
  import prince_cfb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decrypt,
  input  logic        iv_load,
  input  logic [63:0] iv,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic        core_start,
  output logic        core_encrypt,
  output logic [1:0]  core_idx,
  output logic [15:0] core_din,
  input  logic        core_done,
  input  logic [15:0] core_dout,
  output logic        busy,
  output logic        err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e           state_q, state_d;
  logic [BLK_W-1:0] fb_q, fb_d;
  logic [BLK_W-1:0] e_q, e_d;
  logic [BLK_W-1:0] piv_q, piv_d;
  logic [1:0]       slice_q, slice_d;
  logic [1:0]       w_q, w_d;
  logic [1:0]       cidx_q, cidx_d;
  logic             dec_q, dec_d;
  logic             pdec_q, pdec_d;
  logic             err_q, err_d;
  logic             wait_q, wait_d;
  logic             cs_q, cs_d;
  logic             mv_q, mv_d;
  logic             ml_q, ml_d;
  logic [SEG_W-1:0] md_q, md_d;
  logic [SEG_W-1:0] cdin_q, cdin_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;

  logic             acc;
  logic             tmo;
  logic             load;
  logic             load_dec;
  logic [BLK_W-1:0] load_iv;
  logic [1:0]       slot;
  logic [SEG_W-1:0] ow;

  assign core_encrypt = 1'b1;
  assign core_start   = cs_q;
  assign core_idx     = cidx_q;
  assign core_din     = cdin_q;
  assign m_valid      = mv_q;
  assign m_data       = md_q;
  assign m_last       = ml_q;
  assign err_timeout  = err_q;
  assign busy         = (state_q != IDLE);

  assign s_ready = (state_q == XOR) & ~iv_load
                 & (~mv_q | m_ready);
  assign acc     = s_valid & s_ready;
  assign tmo     = wait_q & ~core_done
                 & (tcnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d  = state_q;
    fb_d     = fb_q;
    e_d      = e_q;
    piv_d    = piv_q;
    slice_d  = slice_q;
    w_d      = w_q;
    cidx_d   = cidx_q;
    cdin_d   = cdin_q;
    dec_d    = dec_q;
    pdec_d   = pdec_q;
    err_d    = err_q;
    wait_d   = wait_q;
    cs_d     = 1'b0;
    mv_d     = mv_q;
    ml_d     = ml_q;
    md_d     = md_q;
    tcnt_d   = wait_q ? tcnt_q + 1'b1 : '0;
    load     = 1'b0;
    load_iv  = iv;
    load_dec = decrypt;
    slot     = 2'd3 - w_q;
    ow       = s_data ^ slice_sel(e_q, slot);

    // Output register drains regardless of state.
    if (acc) begin
      mv_d = 1'b1;
      md_d = ow;
      ml_d = s_last;
    end else if (m_ready) begin
      mv_d = 1'b0;
    end

    if (iv_load) err_d = 1'b0;

    case (state_q)
      IDLE: load = iv_load;
      GEN: begin
        if (iv_load) begin
          if (wait_q && !core_done) begin
            state_d = DRAIN;
            piv_d   = iv;
            pdec_d  = decrypt;
          end else begin
            load = 1'b1;
          end
        end else if (wait_q) begin
          if (core_done) begin
            e_d[SEG_W*int'(slice_q) +: SEG_W] = core_dout;
            wait_d = 1'b0;
            if (slice_q == 2'd0) begin
              state_d = XOR;
              w_d     = 2'd0;
              slice_d = 2'd3;
            end else begin
              slice_d = slice_q - 1'b1;
            end
          end else if (tmo) begin
            err_d   = 1'b1;
            wait_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cs_d   = 1'b1;
          cidx_d = slice_q;
          cdin_d = slice_sel(fb_q, slice_q);
          wait_d = 1'b1;
        end
      end
      XOR: begin
        if (iv_load) begin
          load = 1'b1;
        end else if (acc) begin
          fb_d[SEG_W*int'(slot) +: SEG_W] =
            dec_q ? s_data : ow;
          if (s_last) begin
            state_d = IDLE;
          end else if (w_q == 2'd3) begin
            state_d = GEN;
            w_d     = 2'd0;
          end else begin
            w_d = w_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (iv_load) begin
          piv_d  = iv;
          pdec_d = decrypt;
        end
        // Abandoned result (or its timeout) releases the pending IV.
        if (core_done || tmo) begin
          load     = 1'b1;
          load_iv  = piv_d;
          load_dec = pdec_d;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      fb_d    = load_iv;
      dec_d   = load_dec;
      slice_d = 2'd3;
      w_d     = 2'd0;
      wait_d  = 1'b0;
      tcnt_d  = '0;
      state_d = GEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fb_q    <= '0;
      e_q     <= '0;
      piv_q   <= '0;
      slice_q <= 2'd3;
      w_q     <= 2'd0;
      cidx_q  <= 2'd0;
      cdin_q  <= '0;
      dec_q   <= 1'b0;
      pdec_q  <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= 1'b0;
      cs_q    <= 1'b0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
      md_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fb_q    <= fb_d;
      e_q     <= e_d;
      piv_q   <= piv_d;
      slice_q <= slice_d;
      w_q     <= w_d;
      cidx_q  <= cidx_d;
      cdin_q  <= cdin_d;
      dec_q   <= dec_d;
      pdec_q  <= pdec_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      cs_q    <= cs_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
      md_q    <= md_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_prince_cfb_ctrl.sv
// Bench for prince_cfb_ctrl with a stub core (dout = din ^ A5A5).
// Directed table, corner sequences and a random stream model.
module tb_prince_cfb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        decrypt = 1'b0;
  logic        iv_load = 1'b0;
  logic [63:0] iv_in = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic        m_last;
  logic        core_start;
  logic        core_encrypt;
  logic [1:0]  core_idx;
  logic [15:0] core_din;
  logic        core_done;
  logic [15:0] core_dout;
  logic        busy;
  logic        err_timeout;

  always #5 clk = ~clk;

  prince_cfb_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .decrypt(decrypt),
    .iv_load(iv_load), .iv(iv_in),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last),
    .core_start(core_start),
    .core_encrypt(core_encrypt),
    .core_idx(core_idx), .core_din(core_din),
    .core_done(core_done), .core_dout(core_dout),
    .busy(busy), .err_timeout(err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Stub core: done three cycles after the start cycle.
  logic        hang = 1'b0;
  int          scnt;
  logic [15:0] sd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt      <= 0;
      sd        <= '0;
      core_done <= 1'b0;
      core_dout <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start && !hang) begin
        scnt <= 1;
        sd   <= core_din ^ 16'hA5A5;
      end else if (scnt == 1) begin
        scnt <= 2;
      end else if (scnt == 2) begin
        scnt      <= 0;
        core_done <= 1'b1;
        core_dout <= sd;
      end
    end
  end

  logic [17:0] st_q[$];
  logic [16:0] got_q[$];
  always @(posedge clk) begin
    if (core_start) st_q.push_back({core_idx, core_din});
    if (m_valid && m_ready) got_q.push_back({m_last, m_data});
  end

  logic mr_rand = 1'b0;
  logic mr_man  = 1'b1;
  always @(negedge clk)
    m_ready <= mr_rand ? 1'($urandom_range(0, 1)) : mr_man;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_stream(input logic [63:0] v,
                              input logic d);
    iv_in   = v;
    decrypt = d;
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] d,
                           input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) expire("push");
    else tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_starts(input int k);
    int n;
    n = 0;
    while (st_q.size() < k && n < 300) begin
      tick();
      n++;
    end
    if (st_q.size() < k) expire("starts");
  endtask

  task automatic wait_outs(input int k);
    int n;
    n = 0;
    while (got_q.size() < k && n < 400) begin
      tick();
      n++;
    end
    if (got_q.size() < k) expire("outs");
  endtask

  typedef struct {
    logic        dec;
    logic [63:0] iv;
    logic [63:0] din;
    logic [63:0] dout;
    logic [63:0] nfb;
  } vec_t;

  vec_t tbl[2];

  // Block-level CFB reference: keystream = fb ^ A5A5.., ct feeds back.
  logic [15:0] exp_q[$];
  task automatic model(input logic [63:0] v, input logic d,
                       input logic [15:0] words[$]);
    logic [63:0] fb, ks, ct;
    logic [15:0] o;
    fb = v;
    ks = '0;
    ct = '0;
    exp_q.delete();
    for (int j = 0; j < words.size(); j++) begin
      int w;
      w = j % 4;
      if (w == 0) ks = fb ^ {4{16'hA5A5}};
      o = words[j] ^ ks[63-16*w -: 16];
      exp_q.push_back(o);
      ct[63-16*w -: 16] = d ? words[j] : o;
      if (w == 3) fb = ct;
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 64'h0123456789ABCDEF, 64'h0,
               64'hA486E0C22C0E684A, 64'hA486E0C22C0E684A};
    tbl[1] = '{1'b1, 64'h0123456789ABCDEF,
               64'hA486E0C22C0E684A, 64'h0,
               64'hA486E0C22C0E684A};

    repeat (3) tick();
    check("rst busy", busy, 0);
    check("rst m_valid", m_valid, 0);
    check("rst core_start", core_start, 0);
    check("rst core_encrypt", core_encrypt, 1);
    check("rst err", err_timeout, 0);
    check("rst s_ready", s_ready, 0);
    check("rst m_data", m_data, 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 2; t++) begin
      st_q.delete();
      got_q.delete();
      start_stream(tbl[t].iv, tbl[t].dec);
      check("busy", busy, 1);
      wait_starts(4);
      for (int i = 0; i < 4; i++) begin
        check("gen idx", st_q[i][17:16], 3 - i);
        check("gen din", st_q[i][15:0], tbl[t].iv[63-16*i -: 16]);
      end
      for (int i = 0; i < 4; i++)
        push_word(tbl[t].din[63-16*i -: 16], 1'b0);
      wait_outs(4);
      for (int i = 0; i < 4; i++)
        check("tbl out", got_q[i], {1'b0, tbl[t].dout[63-16*i -: 16]});
      wait_starts(8);
      for (int i = 0; i < 4; i++)
        check("next fb", st_q[4+i][15:0], tbl[t].nfb[63-16*i -: 16]);
      repeat (8) tick();
    end

    // Back-pressure on the first output.
    st_q.delete();
    got_q.delete();
    start_stream(64'h0123456789ABCDEF, 1'b0);
    wait_starts(4);
    mr_man = 1'b0;
    tick();
    push_word(16'h0, 1'b0);
    s_valid = 1'b1;
    s_data  = 16'h0;
    for (int k = 0; k < 5; k++) begin
      check("bp s_ready", s_ready, 0);
      check("bp m_data", m_data, 16'hA486);
      check("bp m_valid", m_valid, 1);
      tick();
    end
    mr_man = 1'b1;
    for (int i = 1; i < 4; i++) push_word(16'h0, 1'b0);
    wait_outs(4);
    repeat (3) tick();
    check("bp count", got_q.size(), 4);
    check("bp out0", got_q[0], {1'b0, 16'hA486});
    check("bp out1", got_q[1], {1'b0, 16'hE0C2});
    check("bp out2", got_q[2], {1'b0, 16'h2C0E});
    check("bp out3", got_q[3], {1'b0, 16'h684A});
    repeat (30) tick();

    // Stream ending on word 1.
    st_q.delete();
    got_q.delete();
    start_stream(64'h0123456789ABCDEF, 1'b0);
    push_word(16'h0, 1'b0);
    push_word(16'h0, 1'b1);
    repeat (20) tick();
    check("last count", got_q.size(), 2);
    check("last out0", got_q[0], {1'b0, 16'hA486});
    check("last out1", got_q[1], {1'b1, 16'hE0C2});
    check("last busy", busy, 0);
    check("last starts", st_q.size(), 4);

    // Abort one cycle after the slice-2 start.
    st_q.delete();
    got_q.delete();
    start_stream(64'h0123456789ABCDEF, 1'b0);
    wait_starts(2);
    start_stream(64'h1, 1'b0);
    check("drain busy", busy, 1);
    wait_starts(6);
    check("drain idx", st_q[2][17:16], 3);
    check("drain din", st_q[2][15:0], 16'h0000);
    check("drain din0", st_q[5], {2'd0, 16'h0001});
    for (int i = 0; i < 4; i++) push_word(16'h0, 1'b0);
    wait_outs(4);
    check("drain out2", got_q[2], {1'b0, 16'hA5A5});
    check("drain out3", got_q[3], {1'b0, 16'hA5A4});
    repeat (30) tick();

    // Core never answers.
    hang = 1'b1;
    st_q.delete();
    start_stream(64'hDEADBEEF00C0FFEE, 1'b0);
    wait_starts(1);
    repeat (62) tick();
    check("tmo early", err_timeout, 0);
    tick();
    check("tmo err", err_timeout, 1);
    check("tmo busy", busy, 0);
    hang = 1'b0;
    start_stream(64'h0123456789ABCDEF, 1'b0);
    check("tmo clear", err_timeout, 0);
    repeat (30) tick();

    // Random streams with random back-pressure.
    mr_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      logic [63:0] v;
      logic        d;
      int          len;
      logic [15:0] words[$];
      v   = {$urandom, $urandom};
      d   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      words.delete();
      for (int j = 0; j < len; j++)
        words.push_back(16'($urandom));
      model(v, d, words);
      got_q.delete();
      start_stream(v, d);
      for (int j = 0; j < len; j++)
        push_word(words[j], j == len - 1);
      wait_outs(len);
      for (int j = 0; j < len && j < got_q.size(); j++)
        check("rnd out", got_q[j], {j == len - 1, exp_q[j]});
      check("rnd busy", busy, 0);
    end
    mr_rand = 1'b0;
    repeat (3) tick();

    // Asynchronous reset mid-generation.
    st_q.delete();
    start_stream(64'h0123456789ABCDEF, 1'b0);
    wait_starts(1);
    #1 rst_n = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst start", core_start, 0);
    check("arst m_valid", m_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
